// File: rtl/hilo_muldiv_if.sv
// Request/read bus between the pipeline and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             rd_en;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, A, B, rd_en, rd_sel,
    input  rd_data, busy, stall, done, div_by_zero
  );

  modport slave (
    input  start, op, A, B, rd_en, rd_sel,
    output rd_data, busy, stall, done, div_by_zero
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit with MIPS-style HI/LO result registers.
// Shift-add multiply and restoring divide run on magnitudes; signs are fixed up in FIX.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  hilo_muldiv_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           r_state;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_acc;
  logic             r_is_div, r_neg_p, r_neg_r;
  logic             r_busy, r_done, r_dbz;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return neg ? $unsigned(-s) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic [2*WIDTH-1:0] v, input logic neg);
    logic signed [2*WIDTH-1:0] s;
    s = $signed(v);
    return neg ? $unsigned(-s) : v;
  endfunction

  logic             w_sa, w_sb;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo, w_rem;

  assign w_sa    = bus.op[0] & bus.A[WIDTH-1];
  assign w_sb    = bus.op[0] & bus.B[WIDTH-1];

  // Multiply step: add multiplicand when the current multiplier LSB is set, then shift right.
  assign w_add   = r_acc + {1'b0, (r_q[0] ? r_b : {WIDTH{1'b0}})};

  // Divide step: shift next dividend bit into the partial remainder and try subtracting.
  assign w_trial = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_ge    = (w_trial >= {1'b0, r_b});
  assign w_sub   = w_trial - {1'b0, r_b};

  assign w_prod  = neg_if_wide({r_acc[WIDTH-1:0], r_q}, r_neg_p);
  assign w_quo   = neg_if(r_q, r_neg_p);
  assign w_rem   = neg_if(r_acc[WIDTH-1:0], r_neg_r);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_a_raw  <= '0;
      r_b      <= '0;
      r_q      <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
      r_neg_p  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_raw  <= bus.A;
            r_q      <= neg_if(bus.A, w_sa);
            r_b      <= neg_if(bus.B, w_sb);
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= bus.op[1];
            r_neg_p  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_dbz    <= bus.op[1] & (bus.B == '0);
            r_busy   <= 1'b1;
            r_state  <= bus.op[1] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          r_acc <= {1'b0, w_add[WIDTH:1]};
          r_q   <= {w_add[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_DIV: begin
          r_acc <= w_ge ? w_sub : w_trial;
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_is_div) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (r_dbz) begin
            // Divide by zero returns the raw dividend in HI and all-ones in LO.
            r_hi <= r_a_raw;
            r_lo <= {WIDTH{1'b1}};
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_data     = bus.rd_sel ? r_hi : r_lo;
  assign bus.busy        = r_busy;
  assign bus.stall       = bus.rd_en & r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized self-checking bench for hilo_muldiv_unit against an arithmetic HI/LO model.
module tb_hilo_muldiv_unit;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [31:0] m_hi, m_lo;

  hilo_muldiv_if #(.WIDTH(32)) dif ();

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural operand values.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = 64'(sa * sb);            hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin hi = a % b; lo = a / b; end
      end
      default: begin
        if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin
          q = sa / sb;
          r = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end
      end
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    dif.rd_en  = 1'b1;
    dif.rd_sel = 1'b0;
    #1;
    chk({tag, "_busy"},  {63'b0, dif.busy}, 64'd0);
    chk({tag, "_done"},  {63'b0, dif.done}, 64'd0);
    chk({tag, "_stall"}, {63'b0, dif.stall}, 64'd0);
    chk({tag, "_dbz"},   {63'b0, dif.div_by_zero}, 64'd0);
    chk({tag, "_lo"},    {32'b0, dif.rd_data}, 64'd0);
    dif.rd_sel = 1'b1;
    #1;
    chk({tag, "_hi"},    {32'b0, dif.rd_data}, 64'd0);
    dif.rd_en  = 1'b0;
  endtask

  // Issue one operation; optionally abort it with reset at edge abort_at.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int abort_at);
    logic [31:0] ehi, elo;
    int cyc;
    bit seen;
    model(op, a, b, ehi, elo);
    dif.start = 1'b1;
    dif.op    = op;
    dif.A     = a;
    dif.B     = b;
    @(negedge clk);
    dif.start = 1'b0;
    chk("busy_at_accept", {63'b0, dif.busy}, 64'd1);
    chk("dbz_at_accept", {63'b0, dif.div_by_zero}, {63'b0, (op[1] && b == 0)});
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        dif.start = 1'b1;
        dif.op    = 2'($urandom_range(0, 3));
        dif.A     = $urandom;
        dif.B     = $urandom;
      end
      if (cyc == 6) dif.start = 1'b0;
      if (cyc == 10) begin
        dif.rd_en  = 1'b1;
        dif.rd_sel = 1'b0;
        #1;
        chk("stall_busy", {63'b0, dif.stall}, 64'd1);
        chk("old_lo_busy", {32'b0, dif.rd_data}, {32'b0, m_lo});
        dif.rd_sel = 1'b1;
        #1;
        chk("old_hi_busy", {32'b0, dif.rd_data}, {32'b0, m_hi});
        dif.rd_en = 1'b0;
      end
      if (abort_at != 0 && cyc == abort_at) begin
        reset = 1'b1;
        m_hi  = '0;
        m_lo  = '0;
        check_reset_outputs("abort");
        @(negedge clk);
        chk("abort_no_done", {63'b0, dif.done}, 64'd0);
        reset = 1'b0;
        return;
      end
      if (dif.done) seen = 1'b1;
    end
    chk("latency", 64'(cyc), 64'd33);
    dif.rd_en  = 1'b1;
    dif.rd_sel = 1'b0;
    #1;
    chk("stall_at_done", {63'b0, dif.stall}, 64'd0);
    chk("lo", {32'b0, dif.rd_data}, {32'b0, elo});
    dif.rd_sel = 1'b1;
    #1;
    chk("hi", {32'b0, dif.rd_data}, {32'b0, ehi});
    chk("dbz", {63'b0, dif.div_by_zero}, {63'b0, (op[1] && b == 0)});
    dif.rd_en = 1'b0;
    m_hi = ehi;
    m_lo = elo;
    @(negedge clk);
    chk("done_one_cycle", {63'b0, dif.done}, 64'd0);
    chk("busy_after", {63'b0, dif.busy}, 64'd0);
  endtask

  logic [31:0] corners [0:6];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_hi    = '0;
    m_lo    = '0;
    corners[0] = 32'h00000000;
    corners[1] = 32'h00000001;
    corners[2] = 32'hFFFFFFFF;
    corners[3] = 32'h80000000;
    corners[4] = 32'h7FFFFFFF;
    corners[5] = 32'h00000007;
    corners[6] = 32'hFFFFFFF9;
    dif.start  = 1'b0;
    dif.op     = 2'b00;
    dif.A      = '0;
    dif.B      = '0;
    dif.rd_en  = 1'b0;
    dif.rd_sel = 1'b0;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, 0);
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 0);
    run_op(2'b10, 32'd100, 32'd7, 0);
    run_op(2'b10, 32'h12345678, 32'h0, 0);
    run_op(2'b00, 32'd2, 32'd3, 0);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(2'b11, 32'h87654321, 32'h0, 0);
    run_op(2'b01, $urandom, $urandom, 20);
    run_op(2'b00, 32'd2, 32'd3, 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 6)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 6)] : $urandom;
      if ($urandom_range(0, 4) == 0) b = {28'b0, 4'($urandom_range(0, 15))};
      run_op(op, a, b, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new multiply/divide; sampled only while busy=0.
REQ-005 op  input  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
REQ-006 A  input  32  multiplicand/dividend; captured on accepted start.
REQ-007 B  input  32  multiplier/divisor; captured on accepted start.
REQ-008 rd_en  input  1  mfhi/mflo read request.
REQ-009 rd_sel  input  1  read select: 0 = LO, 1 = HI.
REQ-010 rd_data  output  32  selected register value (HI or LO), combinational from the registers.
REQ-011 busy  output  1  operation in progress.
REQ-012 stall  output  1  rd_en & busy; pipeline holds the read while this is high.
REQ-013 done  output  1  one-cycle pulse when HI/LO are updated.
REQ-014 div_by_zero  output  1  last accepted divide had B=0; held until the next accepted start.

Function
REQ-015 States SHALL be IDLE, MUL, DIV and FIX; IDLE is the reset state.
- IDLE -> MUL on start with op[1]=0.
- IDLE -> DIV on start with op[1]=1.
- MUL/DIV -> FIX after 32 iteration cycles.
- FIX -> IDLE after 1 cycle.
REQ-016 The start-accept edge is edge 0; busy SHALL be high from edge 0 until edge 33.
- Edges 1-32: iterations.
- Edge 33: HI/LO written, busy cleared, done high for exactly one cycle.
REQ-017 start while busy=1 SHALL be ignored, with no effect on state, operands or outputs.
REQ-018 Operand capture SHALL take magnitudes for signed ops (op[0]=1) and record the operand signs; unsigned ops use the operands as-is.
REQ-019 MUL SHALL be radix-2 shift-add on magnitudes, producing a 64-bit product; FIX writes HI = product[63:32] and LO = product[31:0].
- For mult, the product is two's-complement negated in FIX when sign(A) xor sign(B).
REQ-020 DIV SHALL be 32-step restoring division on magnitudes, producing quotient q and remainder r; FIX writes LO = q and HI = r.
- For div, q is negated when sign(A) xor sign(B).
- For div, r is negated when sign(A)=1.
REQ-021 Divide by zero, on B=0 for divu or div:
- div_by_zero SHALL set at the accept edge.
- Iterations still run for the full latency.
- FIX SHALL write HI = A as captured and LO = 0xFFFFFFFF, with no sign correction.
REQ-022 div with A=0x80000000 and B=0xFFFFFFFF SHALL yield LO = 0x80000000 and HI = 0, with div_by_zero = 0.
REQ-023 HI and LO SHALL change only at the FIX edge.
- While busy, rd_data returns the previous HI/LO values.
REQ-024 A rd_en in the same cycle as done=1 SHALL see the new HI/LO values, with stall = 0.
REQ-025 div_by_zero SHALL clear on every accepted start whose op is not a divide with B=0.

Reset
REQ-026 While reset=1, regardless of clock:
- state = IDLE.
- HI = LO = 0 and all operand/iteration registers = 0.
- busy = done = stall = div_by_zero = 0, and rd_data = 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation, with no done pulse.
- HI/LO stay 0 after deassertion.
REQ-028 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-029 multu with A=0xFFFFFFFF, B=0xFFFFFFFF -> done on edge 33 after accept; HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-030 mult with A=0xFFFFFFFD (-3), B=0x00000007 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB (-21).
REQ-031 div with A=0xFFFFFFF9 (-7), B=0x00000002 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1); divu with A=100, B=7 -> LO = 14, HI = 2.
REQ-032 divu with A=0x12345678, B=0 -> div_by_zero = 1; HI = 0x12345678, LO = 0xFFFFFFFF; a following multu with A=2, B=3 clears div_by_zero and gives LO = 6, HI = 0.
REQ-033 Read during busy (rd_en=1, rd_sel=0 at edge 10) -> stall = 1 and rd_data = old LO; a second start at edge 5 is ignored; the result matches the first operation.
REQ-034 reset pulsed at edge 20 of a mult -> busy = 0, no done pulse, HI = LO = 0; a new start accepted right after deassertion completes 33 edges later.
